// File: rtl/pwl2bit_pkg.sv
// Shared types and fixed-point PWL evaluation for the pwl2bit slicer.
// Voltages are signed codes with 4096 codes per volt; time is counted in clock periods.
package pwl2bit_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TIME_W = 16;
  localparam int EVAL_W = DATA_W + COEF_W + 2;
  localparam int DEB_W  = 4;

  typedef struct packed {
    logic signed [DATA_W-1:0] a;
    logic signed [COEF_W-1:0] b;
    logic [TIME_W-1:0]        t0;
  } pwl_t;

  typedef enum logic [1:0] {LOW, PEND_HI, HIGH, PEND_LO} slc_state_t;

  // v = a + b*(t_now - t0), evaluated wide enough that it can never overflow.
  function automatic logic signed [EVAL_W-1:0] pwl_eval(input pwl_t p,
                                                         input logic [TIME_W-1:0] t_now);
    logic [TIME_W-1:0]        dt;
    logic signed [EVAL_W-1:0] a_x;
    logic signed [EVAL_W-1:0] b_x;
    logic signed [EVAL_W-1:0] dt_x;
    dt   = t_now - p.t0;
    a_x  = {{(EVAL_W-DATA_W){p.a[DATA_W-1]}}, p.a};
    b_x  = {{(EVAL_W-COEF_W){p.b[COEF_W-1]}}, p.b};
    dt_x = {{(EVAL_W-TIME_W){1'b0}}, dt};
    return a_x + b_x * dt_x;
  endfunction

endpackage

// File: rtl/pwl_hyst_cmp.sv
// PWL evaluation against a local time base followed by a hysteresis comparator.
module pwl_hyst_cmp
  import pwl2bit_pkg::*;
#(
  parameter logic signed [DATA_W-1:0] VTH  = 16'sd2048,
  parameter logic [DATA_W-1:0]        VHYS = 16'd410,
  parameter logic                     INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  pwl_t in,
  output logic cmp,
  output logic cmp_flip
);

  localparam logic signed [EVAL_W-1:0] VTH_X    = {{(EVAL_W-DATA_W){VTH[DATA_W-1]}}, VTH};
  localparam logic signed [EVAL_W-1:0] HALF_HYS = {{(EVAL_W-DATA_W+1){1'b0}}, VHYS[DATA_W-1:1]};
  localparam logic signed [EVAL_W-1:0] TRIP_HI  = VTH_X + HALF_HYS;
  localparam logic signed [EVAL_W-1:0] TRIP_LO  = VTH_X - HALF_HYS;

  logic [TIME_W-1:0]        r_tnow;
  logic                     r_cmp;
  logic signed [EVAL_W-1:0] w_v;
  logic                     w_cmp_nxt;

  assign w_v = pwl_eval(in, r_tnow);

  // Upper trip is tested first so a zero-width band resolves a tie to 1.
  always_comb begin
    w_cmp_nxt = r_cmp;
    if (en) begin
      if (w_v >= TRIP_HI)      w_cmp_nxt = 1'b1;
      else if (w_v <= TRIP_LO) w_cmp_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tnow <= '0;
      r_cmp  <= INIT;
    end else begin
      r_tnow <= r_tnow + TIME_W'(1);
      r_cmp  <= w_cmp_nxt;
    end
  end

  assign cmp      = r_cmp;
  assign cmp_flip = w_cmp_nxt ^ r_cmp;

endmodule

// File: rtl/pwl2bit_sync.sv
// PWL-to-logic receiver: hysteresis slicer, N-sample debounce FSM, edge pulses and
// a saturating transition counter.
module pwl2bit_sync
  import pwl2bit_pkg::*;
#(
  parameter logic signed [DATA_W-1:0] VTH   = 16'sd2048,
  parameter logic [DATA_W-1:0]        VHYS  = 16'd410,
  parameter int                       N_DEB = 2,
  parameter int                       CNT_W = 8,
  parameter logic                     INIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  pwl_t             in,
  output logic             out,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] cnt,
  output logic             valid
);

  localparam logic [DEB_W-1:0] DEB_TGT   = DEB_W'(N_DEB);
  localparam slc_state_t       RST_STATE = INIT ? HIGH : LOW;

  slc_state_t       r_state;
  logic [DEB_W-1:0] r_deb;
  logic             r_out;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             w_cmp;
  logic             w_cmp_flip;
  logic             w_smp;
  logic [DEB_W-1:0] w_deb_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  pwl_hyst_cmp #(
    .VTH  (VTH),
    .VHYS (VHYS),
    .INIT (INIT)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in       (in),
    .cmp      (w_cmp),
    .cmp_flip (w_cmp_flip)
  );

  // The debouncer counts the sample being taken on this edge, not the previous one,
  // so the N_DEB-th agreeing sample commits out on its own edge.
  assign w_smp     = w_cmp ^ w_cmp_flip;
  assign w_deb_inc = r_deb + DEB_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_deb   <= '0;
      r_out   <= INIT;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (en) begin
        r_valid <= 1'b1;
        case (r_state)
          LOW: begin
            if (w_smp) begin
              if (DEB_TGT == DEB_W'(1)) begin
                r_state <= HIGH;
                r_out   <= 1'b1;
                r_rise  <= 1'b1;
                r_cnt   <= sat_inc(r_cnt);
              end else begin
                r_state <= PEND_HI;
                r_deb   <= DEB_W'(1);
              end
            end
          end
          PEND_HI: begin
            if (!w_smp) begin
              r_state <= LOW;
              r_deb   <= '0;
            end else if (w_deb_inc == DEB_TGT) begin
              r_state <= HIGH;
              r_deb   <= '0;
              r_out   <= 1'b1;
              r_rise  <= 1'b1;
              r_cnt   <= sat_inc(r_cnt);
            end else begin
              r_deb <= w_deb_inc;
            end
          end
          HIGH: begin
            if (!w_smp) begin
              if (DEB_TGT == DEB_W'(1)) begin
                r_state <= LOW;
                r_out   <= 1'b0;
                r_fall  <= 1'b1;
                r_cnt   <= sat_inc(r_cnt);
              end else begin
                r_state <= PEND_LO;
                r_deb   <= DEB_W'(1);
              end
            end
          end
          PEND_LO: begin
            if (w_smp) begin
              r_state <= HIGH;
              r_deb   <= '0;
            end else if (w_deb_inc == DEB_TGT) begin
              r_state <= LOW;
              r_deb   <= '0;
              r_out   <= 1'b0;
              r_fall  <= 1'b1;
              r_cnt   <= sat_inc(r_cnt);
            end else begin
              r_deb <= w_deb_inc;
            end
          end
          default: begin
            r_state <= RST_STATE;
            r_deb   <= '0;
          end
        endcase
      end
    end
  end

  assign out   = r_out;
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign cnt   = r_cnt;
  assign valid = r_valid;

endmodule

// File: tb/tb_pwl2bit_sync.sv
// Directed bench: three slicer instances (debounce 2, debounce 3 with 2-bit counter,
// debounce 1 with zero hysteresis) share clock, reset, enable and the PWL input.
module tb_pwl2bit_sync;
  import pwl2bit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  pwl_t in_s = '0;

  logic       a_out, a_rise, a_fall, a_valid;
  logic [7:0] a_cnt;
  logic       b_out, b_rise, b_fall, b_valid;
  logic [1:0] b_cnt;
  logic       c_out, c_rise, c_fall, c_valid;
  logic [7:0] c_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwl2bit_sync #(.N_DEB(2), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .in(in_s),
    .out(a_out), .rise(a_rise), .fall(a_fall), .cnt(a_cnt), .valid(a_valid));

  pwl2bit_sync #(.N_DEB(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .in(in_s),
    .out(b_out), .rise(b_rise), .fall(b_fall), .cnt(b_cnt), .valid(b_valid));

  pwl2bit_sync #(.N_DEB(1), .CNT_W(8), .VHYS(16'd0)) u_c (
    .clk(clk), .rst(rst), .en(en), .in(in_s),
    .out(c_out), .rise(c_rise), .fall(c_fall), .cnt(c_cnt), .valid(c_valid));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dc(input int code);
    in_s = '{a: DATA_W'(code), b: '0, t0: '0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    set_dc(0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    set_dc(0);
    #1;
    n_cmp++; if (a_out !== 1'b0) begin n_fail++; $display("FAIL rst_out got=%0b exp=0", a_out); end
    n_cmp++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", a_cnt); end
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", a_valid); end
    n_cmp++; if ({a_rise, a_fall} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses got=%b exp=00", {a_rise, a_fall}); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL valid_en0 got=%0b exp=0", a_valid); end
    en = 1'b1;
    tick();
    n_cmp++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL valid_first got=%0b exp=1", a_valid); end
    n_cmp++; if (a_out !== 1'b0) begin n_fail++; $display("FAIL idle_out got=%0b exp=0", a_out); end
    en = 1'b0;
    tick();
    n_cmp++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL valid_sticky got=%0b exp=1", a_valid); end
  endtask

  // Ramp 0 -> 1 V in 5 clocks: samples 0, 819, 1638, 2457 (first above 2253), 3276, ...
  task automatic test_ramp();
    do_reset();
    en   = 1'b1;
    in_s = '{a: 16'sd0, b: 16'sd819, t0: 16'd0};
    repeat (3) tick();
    n_cmp++; if (a_out !== 1'b0) begin n_fail++; $display("FAIL ramp_pre_a got=%0b exp=0", a_out); end
    n_cmp++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL ramp_pre_c got=%0b exp=0", c_out); end
    tick();
    n_cmp++; if (a_out !== 1'b0) begin n_fail++; $display("FAIL ramp_pend_a got=%0b exp=0", a_out); end
    n_cmp++; if ({c_out, c_rise, c_cnt} !== {1'b1, 1'b1, 8'd1}) begin n_fail++; $display("FAIL ramp_c_commit got=%b/%b/%0d exp=1/1/1", c_out, c_rise, c_cnt); end
    tick();
    n_cmp++; if ({a_out, a_rise, a_cnt} !== {1'b1, 1'b1, 8'd1}) begin n_fail++; $display("FAIL ramp_a_commit got=%b/%b/%0d exp=1/1/1", a_out, a_rise, a_cnt); end
    n_cmp++; if (b_out !== 1'b0) begin n_fail++; $display("FAIL ramp_b_pend got=%0b exp=0", b_out); end
    tick();
    n_cmp++; if ({a_out, a_rise} !== 2'b10) begin n_fail++; $display("FAIL ramp_a_pulse_end got=%b exp=10", {a_out, a_rise}); end
    n_cmp++; if ({b_out, b_rise} !== 2'b11) begin n_fail++; $display("FAIL ramp_b_commit got=%b exp=11", {b_out, b_rise}); end
  endtask

  task automatic test_hysteresis();
    do_reset();
    en = 1'b1;
    set_dc(4096);
    repeat (2) tick();
    n_cmp++; if ({a_out, a_cnt} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL hys_high got=%b/%0d exp=1/1", a_out, a_cnt); end
    set_dc(2130);
    repeat (2) tick();
    set_dc(1966);
    repeat (3) tick();
    n_cmp++; if ({a_out, a_cnt} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL hys_band got=%b/%0d exp=1/1", a_out, a_cnt); end
    n_cmp++; if ({c_out, c_cnt} !== {1'b0, 8'd2}) begin n_fail++; $display("FAIL hys_nohys_c got=%b/%0d exp=0/2", c_out, c_cnt); end
    set_dc(1802);
    tick();
    n_cmp++; if ({a_out, a_fall} !== 2'b10) begin n_fail++; $display("FAIL hys_pend_lo got=%b exp=10", {a_out, a_fall}); end
    tick();
    n_cmp++; if ({a_out, a_fall, a_rise, a_cnt} !== {1'b0, 1'b1, 1'b0, 8'd2}) begin n_fail++; $display("FAIL hys_fall got=%b/%b/%b/%0d exp=0/1/0/2", a_out, a_fall, a_rise, a_cnt); end
    tick();
    n_cmp++; if (a_fall !== 1'b0) begin n_fail++; $display("FAIL hys_fall_end got=%0b exp=0", a_fall); end
  endtask

  // Trip points with default band: upper 2253, lower 1843; zero-band slicer trips at 2048.
  task automatic test_trip_points();
    do_reset();
    en = 1'b1;
    set_dc(2048);
    tick();
    n_cmp++; if ({c_out, c_rise} !== 2'b11) begin n_fail++; $display("FAIL tie_c got=%b exp=11", {c_out, c_rise}); end
    tick();
    n_cmp++; if (a_out !== 1'b0) begin n_fail++; $display("FAIL tie_a_band got=%0b exp=0", a_out); end
    set_dc(2047);
    tick();
    n_cmp++; if ({c_out, c_fall} !== 2'b01) begin n_fail++; $display("FAIL below_tie_c got=%b exp=01", {c_out, c_fall}); end
    set_dc(2253);
    repeat (2) tick();
    n_cmp++; if ({a_out, a_rise} !== 2'b11) begin n_fail++; $display("FAIL trip_hi_exact got=%b exp=11", {a_out, a_rise}); end
    set_dc(1843);
    repeat (2) tick();
    n_cmp++; if ({a_out, a_fall} !== 2'b01) begin n_fail++; $display("FAIL trip_lo_exact got=%b exp=01", {a_out, a_fall}); end
  endtask

  task automatic test_glitch();
    do_reset();
    en = 1'b1;
    set_dc(0);
    tick();
    set_dc(4096);
    repeat (2) tick();
    n_cmp++; if (b_out !== 1'b0) begin n_fail++; $display("FAIL glitch_pend got=%0b exp=0", b_out); end
    set_dc(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({b_out, b_rise, b_fall, b_cnt} !== 5'b00000) begin n_fail++; $display("FAIL glitch_reject[%0d] got=%b/%b/%b/%0d exp=0/0/0/0", i, b_out, b_rise, b_fall, b_cnt); end
    end
    set_dc(4096);
    repeat (3) tick();
    n_cmp++; if ({b_out, b_rise, b_cnt} !== {1'b1, 1'b1, 2'd1}) begin n_fail++; $display("FAIL glitch_full got=%b/%b/%0d exp=1/1/1", b_out, b_rise, b_cnt); end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    en = 1'b1;
    set_dc(4096);
    tick();
    n_cmp++; if (a_out !== 1'b0) begin n_fail++; $display("FAIL en_pend got=%0b exp=0", a_out); end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (a_out !== 1'b0) begin n_fail++; $display("FAIL en_frozen[%0d] got=%0b exp=0", i, a_out); end
    end
    en = 1'b1;
    tick();
    n_cmp++; if ({a_out, a_rise, a_cnt} !== {1'b1, 1'b1, 8'd1}) begin n_fail++; $display("FAIL en_resume got=%b/%b/%0d exp=1/1/1", a_out, a_rise, a_cnt); end
    en = 1'b0;
    tick();
    n_cmp++; if ({a_out, a_rise} !== 2'b10) begin n_fail++; $display("FAIL en_rise_kill got=%b exp=10", {a_out, a_rise}); end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_dc((k % 2 == 0) ? 4096 : 0);
      repeat (3) tick();
    end
    n_cmp++; if ({b_out, b_cnt} !== {1'b1, 2'd3}) begin n_fail++; $display("FAIL sat_b got=%b/%0d exp=1/3", b_out, b_cnt); end
    n_cmp++; if (a_cnt !== 8'd5) begin n_fail++; $display("FAIL sat_a_count got=%0d exp=5", a_cnt); end
    n_cmp++; if (c_cnt !== 8'd5) begin n_fail++; $display("FAIL sat_c_count got=%0d exp=5", c_cnt); end
    set_dc(0);
    tick();
    n_cmp++; if (b_out !== 1'b1) begin n_fail++; $display("FAIL sat_b_pend_lo got=%0b exp=1", b_out); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({b_out, b_cnt, b_valid} !== 4'b0000) begin n_fail++; $display("FAIL async_rst_b got=%b/%0d/%b exp=0/0/0", b_out, b_cnt, b_valid); end
    n_cmp++; if ({a_out, a_cnt} !== 9'd0) begin n_fail++; $display("FAIL async_rst_a got=%b/%0d exp=0/0", a_out, a_cnt); end
    #1;
    rst = 1'b0;
    tick();
    n_cmp++; if ({b_out, b_fall, b_cnt} !== 4'b0000) begin n_fail++; $display("FAIL rst_discard got=%b/%b/%0d exp=0/0/0", b_out, b_fall, b_cnt); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_hysteresis();
    test_trip_points();
    test_glitch();
    test_enable_freeze();
    test_saturation_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwl2bit_sync.md
Name: pwl2bit_sync

Overview:
- Clocked receiver-side converter: samples a PWL analog signal on each rising clock edge and slices it to a logic level.
- Applies hysteresis and N-sample debounce before committing the output.
- Reports rise/fall events and a saturating toggle count.
- Sits at the input of digital blocks that consume mLingua PWL nets, such as data recovered from bit2pwl-driven channels.

Parameters:
- vth, 0.5, slicer centre threshold (V).
- vhys, 0.1, total hysteresis width. Upper trip = vth+vhys/2; lower trip = vth-vhys/2.
- N_DEB, 2, consecutive agreeing samples required to change out. Legal range 1..15.
- CNT_W, 8, width of the toggle counter.
- INIT, 1'b0, logic level of out after reset.

Ports:
- clk  input  1  sampling clock, rising edge active.
- rst  input  1  asynchronous active-high reset.
- en  input  1  sample enable. When low, state, counters and outputs hold.
- in  input  `input_pwl  PWL analog input.
- out  output  1  debounced sliced logic level.
- rise  output  1  one-cycle pulse when out goes 0->1.
- fall  output  1  one-cycle pulse when out goes 1->0.
- cnt  output  CNT_W  saturating count of committed out transitions.
- valid  output  1  high once the first enabled sample after reset has been taken.

Behaviour:
- Reset (async, rst=1): out=INIT, rise=0, fall=0, cnt=0, valid=0, deb counter=0, state=INIT?HIGH:LOW. Reset dominates clk.
- Sampling: on posedge clk with en=1, compute v = in.a + in.b*(t_now - in.t0), with t_now = `get_time. Evaluation uses the PWL evaluation method of the PWL class.
- Comparator (registered, hyst): cmp=1 if v >= vth+vhys/2; cmp=0 if v <= vth-vhys/2; otherwise cmp holds its previous value. The reset value of cmp is INIT.
- FSM states: LOW, PEND_HI, HIGH, PEND_LO.
  - LOW: cmp=1 -> PEND_HI, deb=1. If N_DEB=1, go directly to HIGH.
  - PEND_HI: cmp=1 -> deb++; reaching deb==N_DEB -> HIGH. cmp=0 -> LOW, deb=0.
  - HIGH and PEND_LO: mirror of LOW and PEND_HI.
- Latency: out changes on the edge on which the N_DEB-th agreeing sample is taken. Minimum latency is 1 cycle from the first threshold crossing at a sample point.
- rise/fall: asserted for exactly the cycle following entry into HIGH/LOW from a PEND state; 0 otherwise. Never asserted together.
- cnt: increments on each committed transition and saturates at 2^CNT_W-1. It does not wrap.
- en=0: no sampling; deb and state frozen; rise/fall forced 0 on the next edge. A pending state resumes counting when en returns.
- Boundary conditions:
  - v exactly equal to a trip point counts as crossed.
  - A vhys=0 slicer must be tie-safe: v==vth gives cmp=1.
  - A glitch shorter than N_DEB samples leaves out, cnt, rise and fall unchanged.
  - rst asserted during PEND_*: pending progress is discarded.
  - valid goes high on the first enabled edge and stays high until reset.
- No division anywhere. Slope evaluation is real arithmetic; deb is a 4-bit unsigned counter.

Decomposition:
- Package pwl2bit_pkg:
  - typedef enum {LOW, PEND_HI, HIGH, PEND_LO} slc_state_t;
  - localparam DEB_W=4.
- Sub-module pwl_hyst_cmp holds the real-valued evaluation and hysteresis comparator, with the same clk/rst/en.
  - Inputs: in, clk, rst, en.
  - Output: registered cmp.
- The top level holds the FSM, debounce counter, edge pulses and counter.

Test Plan:
- Reset and hold: rst=1 with INIT=0 -> out=0, cnt=0, valid=0. Release rst, en=1, in=0.0 constant -> valid=1 after 1 edge, out stays 0.
- Clean ramp: in ramps 0->1 V over 5 clocks, N_DEB=2 -> v crosses 0.55 on sample k, out=1 at edge k+1, rise pulse 1 cycle, cnt=1.
- Hysteresis: in settles at 0.52 V after being high, then 0.48 V -> out stays 1 (no trip). Then 0.44 V for 2 samples -> out=0, fall pulse, cnt=2.
- Glitch reject: N_DEB=3, in high for exactly 2 samples then low -> out remains 0, no rise, cnt unchanged.
- Enable freeze: enter PEND_HI, drop en for 4 cycles while in stays 1 V, re-raise en -> out=1 after the remaining N_DEB-1 enabled samples.
- Saturation and mid-op reset: CNT_W=2 with 5 full toggles -> cnt=3. Async rst pulse mid-cycle during PEND_LO -> out=INIT and cnt=0 immediately, with no clk edge needed.
